// File: rtl/instr_mem_loader.sv
// Instruction store for a single-cycle CPU: answers PC fetches combinationally and is
// filled by a byte-serial, length-prefixed big-endian loader that gates cpu_run.
module instr_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        RUN,
        ERR
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          byteCnt_q, byteCnt_d;
    logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
    logic [15:0]         hdrN_q, hdrN_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_W:0]     wordCount_q, wordCount_d;
    logic                loadDone_q, loadDone_d;
    logic                loadErr_q, loadErr_d;
    logic                cpuRun_q, cpuRun_d;

    logic                accept;
    logic                memWe;
    logic [31:0]         memWdata;
    logic [15:0]         nFull;
    logic [ADDR_W:0]     wcInc;
    logic [31:0]         mem [0:DEPTH-1];
    logic                unusedPcBits;

    // Ready is a pure state decode so the loader never sees a valid->ready loop.
    assign byte_ready = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign accept     = byte_valid && byte_ready;
    assign nFull      = {hdrN_q[15:8], byte_data};
    assign wcInc      = wordCount_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byteCnt_q   <= '0;
            wrAddr_q    <= '0;
            hdrN_q      <= '0;
            asm_q       <= '0;
            wordCount_q <= '0;
            loadDone_q  <= 1'b0;
            loadErr_q   <= 1'b0;
            cpuRun_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            byteCnt_q   <= byteCnt_d;
            wrAddr_q    <= wrAddr_d;
            hdrN_q      <= hdrN_d;
            asm_q       <= asm_d;
            wordCount_q <= wordCount_d;
            loadDone_q  <= loadDone_d;
            loadErr_q   <= loadErr_d;
            cpuRun_q    <= cpuRun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byteCnt_d   = byteCnt_q;
        wrAddr_d    = wrAddr_q;
        hdrN_d      = hdrN_q;
        asm_d       = asm_q;
        wordCount_d = wordCount_q;
        loadDone_d  = loadDone_q;
        loadErr_d   = loadErr_q;
        cpuRun_d    = cpuRun_q;
        memWe       = 1'b0;
        memWdata    = {asm_q, byte_data};

        // A restart wins over everything, including a byte offered in the same cycle.
        if (load_start) begin
            state_d     = HDR0;
            byteCnt_d   = '0;
            wrAddr_d    = '0;
            wordCount_d = '0;
            loadDone_d  = 1'b0;
            loadErr_d   = 1'b0;
            cpuRun_d    = 1'b0;
        end else begin
            case (state_q)
                HDR0: begin
                    if (accept) begin
                        hdrN_d[15:8] = byte_data;
                        state_d      = HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        hdrN_d[7:0] = byte_data;
                        if ((nFull == 16'd0) || (32'(nFull) > DEPTH)) begin
                            state_d   = ERR;
                            loadErr_d = 1'b1;
                            cpuRun_d  = 1'b0;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byteCnt_d = byteCnt_q + 2'd1;
                        asm_d     = {asm_q[15:0], byte_data};
                        if (byteCnt_q == 2'd3) begin
                            memWe       = 1'b1;
                            wrAddr_d    = wrAddr_q + ADDR_W'(1);
                            wordCount_d = wcInc;
                            if (32'(wcInc) == 32'(hdrN_q)) begin
                                state_d    = RUN;
                                loadDone_d = 1'b1;
                                cpuRun_d   = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[wrAddr_q] <= memWdata;
        end
    end

    // Byte offset within the word is irrelevant for word fetches.
    assign unusedPcBits = ^pc[1:0];

    always_comb begin
        instr = 32'h0000_0000;
        if ((state_q == RUN) && (pc[31:ADDR_W+2] == '0)) begin
            instr = mem[pc[ADDR_W+1:2]];
        end
    end

    assign cpu_run    = cpuRun_q;
    assign load_done  = loadDone_q;
    assign load_err   = loadErr_q;
    assign word_count = wordCount_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: words are queued as they are loaded
// and popped when fetched back through pc/instr in RUN.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        cpu_run;
    logic        load_done;
    logic        load_err;
    logic [8:0]  word_count;

    int          checks;
    int          failures;
    logic [31:0] expQ[$];
    logic [31:0] lastWord;

    instr_mem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .pc         (pc),
        .instr      (instr),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        load_start = 1'b1;
        nextCycle();
        load_start = 1'b0;
    endtask

    // Offer one byte after `gap` idle cycles; waits (bounded) for ready.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            byte_data  = 8'hEE;
            nextCycle();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        waited = 0;
        while (!byte_ready && waited < 20) begin
            nextCycle();
            waited++;
        end
        if (!byte_ready) begin
            checkOutput("readyTimeout", 32'(byte_ready), 32'd1);
        end
        nextCycle();
        byte_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        expQ.push_back(w);
        lastWord = w;
        applyStimulus(w[31:24], gap);
        applyStimulus(w[23:16], gap);
        applyStimulus(w[15:8], gap);
        applyStimulus(w[7:0], gap);
    endtask

    task automatic readBack(input string tag, input int n);
        logic [31:0] exp;
        for (int i = 0; i < n; i++) begin
            pc  = 32'(i * 4);
            #1;
            exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hXXXX_XXXX;
            checkOutput(tag, instr, exp);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        pc         = 32'h0;
        #12;
        rst_n = 1'b1;
        nextCycle();

        // Reset state
        checkOutput("rstReady", 32'(byte_ready), 32'd0);
        checkOutput("rstRun", 32'(cpu_run), 32'd0);
        checkOutput("rstDone", 32'(load_done), 32'd0);
        checkOutput("rstErr", 32'(load_err), 32'd0);
        checkOutput("rstCount", 32'(word_count), 32'd0);
        checkOutput("rstInstr", instr, 32'h0);

        // Two-word load with cpu_run timing
        pulseStart();
        checkOutput("hdr0Ready", 32'(byte_ready), 32'd1);
        applyStimulus(8'h00, 0);
        checkOutput("hdr1Ready", 32'(byte_ready), 32'd1);
        applyStimulus(8'h02, 0);
        checkOutput("dataReady", 32'(byte_ready), 32'd1);
        sendWord(32'h2408_0005, 0);
        expQ.push_back(32'h0800_0000);
        applyStimulus(8'h08, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkOutput("runBeforeLast", 32'(cpu_run), 32'd0);
        applyStimulus(8'h00, 0);
        checkOutput("runAfterLast", 32'(cpu_run), 32'd1);
        checkOutput("doneTwo", 32'(load_done), 32'd1);
        checkOutput("countTwo", 32'(word_count), 32'd2);
        checkOutput("runReady", 32'(byte_ready), 32'd0);
        readBack("twoWord", 2);
        pc = 32'h6;
        #1;
        checkOutput("pcOffset", instr, 32'h0800_0000);

        // Zero-length and oversize headers
        pulseStart();
        checkOutput("startClearsRun", 32'(cpu_run), 32'd0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        pc = 32'h0;
        #1;
        checkOutput("zeroErr", 32'(load_err), 32'd1);
        checkOutput("zeroRun", 32'(cpu_run), 32'd0);
        checkOutput("zeroReady", 32'(byte_ready), 32'd0);
        checkOutput("zeroInstr", instr, 32'h0);
        pulseStart();
        checkOutput("errCleared", 32'(load_err), 32'd0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h01, 0);
        checkOutput("bigErr", 32'(load_err), 32'd1);
        checkOutput("bigInstr", instr, 32'h0);
        checkOutput("bigDone", 32'(load_done), 32'd0);
        pulseStart();
        checkOutput("bigCleared", 32'(load_err), 32'd0);

        // One-word load with stalls between bytes
        applyStimulus(8'h00, 2);
        applyStimulus(8'h01, 1);
        sendWord(32'hDEAD_BEEF, 2);
        checkOutput("stallCount", 32'(word_count), 32'd1);
        checkOutput("stallRun", 32'(cpu_run), 32'd1);
        readBack("stallWord", 1);

        // Full-depth load and address boundary
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            sendWord($urandom, 0);
        end
        checkOutput("fullCount", 32'(word_count), 32'd256);
        checkOutput("fullDone", 32'(load_done), 32'd1);
        pc = 32'h0000_0400;
        #1;
        checkOutput("pcOutOfRange", instr, 32'h0);
        pc = 32'h0000_03FC;
        #1;
        checkOutput("pcLastWord", instr, lastWord);
        pc = 32'h8000_0000;
        #1;
        checkOutput("pcHighBit", instr, 32'h0);
        readBack("fullWord", 256);

        // Restart in the middle of a data word
        pulseStart();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        nextCycle();
        load_start = 1'b0;
        byte_valid = 1'b0;
        checkOutput("abortReady", 32'(byte_ready), 32'd1);
        checkOutput("abortCount", 32'(word_count), 32'd0);
        checkOutput("abortRun", 32'(cpu_run), 32'd0);
        checkOutput("abortDone", 32'(load_done), 32'd0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        sendWord(32'h1234_5678, 0);
        checkOutput("reloadRun", 32'(cpu_run), 32'd1);
        readBack("reloadWord", 1);

        // Asynchronous reset in the middle of DATA
        pulseStart();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        sendWord(32'hCAFE_F00D, 0);
        void'(expQ.pop_back());
        applyStimulus(8'h55, 0);
        checkOutput("preRstCount", 32'(word_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReady", 32'(byte_ready), 32'd0);
        checkOutput("asyncCount", 32'(word_count), 32'd0);
        checkOutput("asyncRun", 32'(cpu_run), 32'd0);
        #3;
        rst_n = 1'b1;
        nextCycle();
        nextCycle();
        pc = 32'h0;
        #1;
        checkOutput("postRstReady", 32'(byte_ready), 32'd0);
        checkOutput("postRstInstr", instr, 32'h0);
        checkOutput("postRstDone", 32'(load_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
